// File: rtl/pal_macrocell_array.sv
// Programmable AND/OR array with per-output macrocells and a length-checked shadow config chain.
// Optional feedback of macrocell flop outputs into the AND plane is enabled by defining PAL_FEEDBACK_EN.
module pal_macrocell_array #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int P = 14
) (
  input  logic         CLK,
  input  logic         RES_N,
  input  logic         CFG_EN,
  input  logic         CFG_IN,
  input  logic         CFG_COMMIT,
  input  logic [N-1:0] INPUT_VARS,
  output logic [M-1:0] OUTPUT_VALS,
  output logic         CFG_OUT,
  output logic         CFG_VALID,
  output logic         CFG_ERR
);

`ifdef PAL_FEEDBACK_EN
  localparam int L = N + M;
`else
  localparam int L = N;
`endif
  localparam int B  = 2 * L * P;
  localparam int D  = B + M * P;
  localparam int C  = D + 2 * M;
  localparam int CW = $clog2(C + 2);

  localparam logic [CW-1:0] CNT_FULL = CW'(C);
  localparam logic [CW-1:0] CNT_SAT  = CW'(C + 1);

  logic [C-1:0]           sr;
  logic [C-1:0]           act;
  logic [CW-1:0]          cnt;
  logic [M-1:0]           q;
  logic [M-1:0]           s;
  logic [L-1:0]           lit;
  logic [P-1:0][L-1:0]    en_t;
  logic [P-1:0][L-1:0]    en_c;
  logic [P-1:0]           prod;
  logic [M-1:0][P-1:0]    conn;
  logic [M-1:0]           mc_reg;
  logic [M-1:0]           mc_inv;

  // Shadow chain, length counter and commit; commit only when not shifting
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      sr        <= '0;
      act       <= '0;
      cnt       <= '0;
      CFG_OUT   <= 1'b0;
      CFG_VALID <= 1'b0;
      CFG_ERR   <= 1'b0;
    end else if (CFG_EN) begin
      sr      <= {CFG_IN, sr[C-1:1]};
      CFG_OUT <= sr[0];
      if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
    end else if (CFG_COMMIT) begin
      cnt <= '0;
      if (cnt == CNT_FULL) begin
        act       <= sr;
        CFG_VALID <= 1'b1;
        CFG_ERR   <= 1'b0;
      end else begin
        CFG_ERR <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) q <= '0;
    else        q <= s;
  end

`ifdef PAL_FEEDBACK_EN
  // Feedback always taps the flop, never the combinational path, so no loops form
  assign lit = {q, INPUT_VARS};
`else
  assign lit = INPUT_VARS;
`endif

  always_comb begin
    en_t = '0;
    en_c = '0;
    for (int unsigned p = 0; p < P; p++) begin
      for (int unsigned i = 0; i < L; i++) begin
        en_t[p][i] = act[2*L*p + 2*i];
        en_c[p][i] = act[2*L*p + 2*i + 1];
      end
    end
  end

  // A row with no enabled literal is forced to 0 instead of the empty-AND 1
  always_comb begin
    prod = '0;
    for (int unsigned p = 0; p < P; p++) begin
      prod[p] = (|en_t[p] | |en_c[p]) & (&(lit | ~en_t[p])) & (&(~lit | ~en_c[p]));
    end
  end

  assign conn = act[B +: M*P];

  always_comb begin
    mc_reg = '0;
    mc_inv = '0;
    for (int unsigned m = 0; m < M; m++) begin
      mc_reg[m] = act[D + 2*m];
      mc_inv[m] = act[D + 2*m + 1];
    end
  end

  always_comb begin
    s = '0;
    for (int unsigned m = 0; m < M; m++) begin
      s[m] = (|(prod & conn[m])) ^ mc_inv[m];
    end
  end

  assign OUTPUT_VALS = (mc_reg & q) | (~mc_reg & s);

endmodule

// File: tb/tb_pal_macrocell_array.sv
// Directed bench for pal_macrocell_array with a scoreboard queue of expected values.
// Define PAL_FEEDBACK_EN for both files to exercise the feedback toggle.
module tb_pal_macrocell_array;

  localparam int N = 8;
  localparam int M = 4;
  localparam int P = 14;
`ifdef PAL_FEEDBACK_EN
  localparam int L = N + M;
`else
  localparam int L = N;
`endif
  localparam int B = 2 * L * P;
  localparam int D = B + M * P;
  localparam int C = D + 2 * M;

  logic         CLK = 1'b0;
  logic         RES_N;
  logic         CFG_EN;
  logic         CFG_IN;
  logic         CFG_COMMIT;
  logic [N-1:0] INPUT_VARS;
  logic [M-1:0] OUTPUT_VALS;
  logic         CFG_OUT;
  logic         CFG_VALID;
  logic         CFG_ERR;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [31:0] exp_q[$];

  pal_macrocell_array #(.N(N), .M(M), .P(P)) dut (
    .CLK        (CLK),
    .RES_N      (RES_N),
    .CFG_EN     (CFG_EN),
    .CFG_IN     (CFG_IN),
    .CFG_COMMIT (CFG_COMMIT),
    .INPUT_VARS (INPUT_VARS),
    .OUTPUT_VALS(OUTPUT_VALS),
    .CFG_OUT    (CFG_OUT),
    .CFG_VALID  (CFG_VALID),
    .CFG_ERR    (CFG_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic shift_bits(input logic [C-1:0] f, input int unsigned n, input bit push);
    for (int unsigned j = 0; j < n; j++) begin
      CFG_EN = 1'b1;
      CFG_IN = f[j];
      if (push) exp(32'(f[j]));
      tick();
    end
    CFG_EN = 1'b0;
    CFG_IN = 1'b0;
  endtask

  task automatic shift_zeros(input int unsigned n);
    for (int unsigned j = 0; j < n; j++) begin
      CFG_EN = 1'b1;
      CFG_IN = 1'b0;
      tick();
    end
    CFG_EN = 1'b0;
  endtask

  task automatic commit();
    CFG_COMMIT = 1'b1;
    tick();
    CFG_COMMIT = 1'b0;
  endtask

  // output0 = in0 & in1 through row 0, with selectable REG/INV
  function automatic logic [C-1:0] frame_a(input logic reg_b, input logic inv_b);
    logic [C-1:0] f;
    f        = '0;
    f[0]     = 1'b1;
    f[2]     = 1'b1;
    f[B]     = 1'b1;
    f[D]     = reg_b;
    f[D + 1] = inv_b;
    return f;
  endfunction

  // row5 = in7 & ~in2 -> outputs 1 and 3; row6 = in3 & ~in3 -> output 1; output 2 inverted constant
  function automatic logic [C-1:0] frame_e();
    logic [C-1:0] f;
    f                   = '0;
    f[2*L*5 + 14]       = 1'b1;
    f[2*L*5 + 5]        = 1'b1;
    f[2*L*6 + 6]        = 1'b1;
    f[2*L*6 + 7]        = 1'b1;
    f[B + P*1 + 5]      = 1'b1;
    f[B + P*3 + 5]      = 1'b1;
    f[B + P*1 + 6]      = 1'b1;
    f[D + 5]            = 1'b1;
    return f;
  endfunction

  function automatic logic [M-1:0] model_e(input logic [N-1:0] v);
    logic r5;
    r5 = v[7] & ~v[2];
    return {r5, 1'b1, r5, 1'b0};
  endfunction

  initial begin
    logic [C-1:0] fr;
    logic [N-1:0] vecs[10];

    RES_N      = 1'b0;
    CFG_EN     = 1'b0;
    CFG_IN     = 1'b0;
    CFG_COMMIT = 1'b0;
    INPUT_VARS = N'($urandom);
    #12;
    exp(0); check("reset_out", 32'(OUTPUT_VALS));
    INPUT_VARS = 8'hFF;
    #3;
    exp(0); check("reset_out_ff", 32'(OUTPUT_VALS));
    exp(0); check("reset_valid", 32'(CFG_VALID));
    exp(0); check("reset_err", 32'(CFG_ERR));
    exp(0); check("reset_cfg_out", 32'(CFG_OUT));
    @(negedge CLK);
    RES_N = 1'b1;
    tick();

    // Combinational AND/OR; shadow contents must not leak before commit
    INPUT_VARS = 8'h03;
    shift_bits(frame_a(1'b0, 1'b0), C, 1'b0);
    exp(0); check("pre_commit_out", 32'(OUTPUT_VALS));
    commit();
    exp(1); check("commit_valid", 32'(CFG_VALID));
    exp(0); check("commit_err", 32'(CFG_ERR));
    exp(4'h1); check("comb_03", 32'(OUTPUT_VALS));
    INPUT_VARS = 8'h01; #1;
    exp(4'h0); check("comb_01", 32'(OUTPUT_VALS));
    INPUT_VARS = 8'hFF; #1;
    exp(4'h1); check("comb_ff", 32'(OUTPUT_VALS));
    INPUT_VARS = 8'h02; #1;
    exp(4'h0); check("comb_02", 32'(OUTPUT_VALS));

    // Registered, inverted macrocell
    INPUT_VARS = 8'h00;
    shift_bits(frame_a(1'b1, 1'b1), C, 1'b0);
    commit();
    exp(4'h0); check("reg_at_commit", 32'(OUTPUT_VALS));
    tick();
    exp(4'h1); check("reg_in00", 32'(OUTPUT_VALS));
    INPUT_VARS = 8'h03; #1;
    exp(4'h1); check("reg_hold", 32'(OUTPUT_VALS));
    tick();
    exp(4'h0); check("reg_in03", 32'(OUTPUT_VALS));
    INPUT_VARS = 8'h00; #1;
    exp(4'h0); check("reg_hold2", 32'(OUTPUT_VALS));
    tick();
    exp(4'h1); check("reg_in00_b", 32'(OUTPUT_VALS));

    // Short frame rejected, previous function kept
    shift_bits(frame_a(1'b0, 1'b0), C - 1, 1'b0);
    commit();
    exp(1); check("short_err", 32'(CFG_ERR));
    exp(1); check("short_valid", 32'(CFG_VALID));
    INPUT_VARS = 8'h03;
    tick();
    exp(4'h0); check("short_keeps_reg", 32'(OUTPUT_VALS));

    // Overlength frame rejected
    shift_bits(frame_a(1'b0, 1'b0), C, 1'b0);
    shift_zeros(1);
    commit();
    exp(1); check("long_err", 32'(CFG_ERR));

    // Exact frame accepted again
    shift_bits(frame_a(1'b0, 1'b0), C, 1'b0);
    commit();
    exp(0); check("exact_err", 32'(CFG_ERR));
    exp(1); check("exact_valid", 32'(CFG_VALID));
    exp(4'h1); check("exact_comb_03", 32'(OUTPUT_VALS));

    // Commit together with shift: shift wins, no commit, no error
    INPUT_VARS = 8'h00;
    shift_bits(frame_a(1'b1, 1'b1), C, 1'b0);
    CFG_EN     = 1'b1;
    CFG_IN     = 1'b0;
    CFG_COMMIT = 1'b1;
    tick();
    CFG_EN     = 1'b0;
    CFG_COMMIT = 1'b0;
    exp(0); check("collide_err", 32'(CFG_ERR));
    tick();
    exp(4'h0); check("collide_no_commit", 32'(OUTPUT_VALS));
    commit();
    exp(1); check("after_collide_err", 32'(CFG_ERR));
    INPUT_VARS = 8'h03; #1;
    exp(4'h1); check("after_collide_func", 32'(OUTPUT_VALS));

    // Multi-output frame against a small model
    shift_bits(frame_e(), C, 1'b0);
    commit();
    exp(0); check("e_err", 32'(CFG_ERR));
    vecs[0] = 8'h80; vecs[1] = 8'h84; vecs[2] = 8'h00; vecs[3] = 8'hFF; vecs[4] = 8'h88;
    for (int i = 5; i < 10; i++) vecs[i] = N'($urandom);
    for (int i = 0; i < 10; i++) begin
      INPUT_VARS = vecs[i];
      #1;
      exp(32'(model_e(vecs[i])));
      check($sformatf("e_vec_%0h", vecs[i]), 32'(OUTPUT_VALS));
    end

    // Readback: each bit reappears on CFG_OUT after C+1 shifts
    for (int i = 0; i < C; i++) fr[i] = 1'($urandom);
    shift_bits(fr, C, 1'b1);
    for (int unsigned k = 0; k < C; k++) begin
      CFG_EN = 1'b1;
      CFG_IN = 1'b0;
      tick();
      check($sformatf("readback_%0d", k), 32'(CFG_OUT));
    end
    CFG_EN = 1'b0;

    // Asynchronous reset mid-operation clears active config
    INPUT_VARS = 8'h80;
    #1;
    RES_N = 1'b0;
    #1;
    exp(4'h0); check("async_rst_out", 32'(OUTPUT_VALS));
    exp(0); check("async_rst_valid", 32'(CFG_VALID));
    @(negedge CLK);
    RES_N = 1'b1;
    tick();
    exp(4'h0); check("post_rst_out", 32'(OUTPUT_VALS));

`ifdef PAL_FEEDBACK_EN
    // Toggle flop: row0 = ~q0, output0 registered
    fr = '0;
    fr[2*N + 1] = 1'b1;
    fr[B]       = 1'b1;
    fr[D]       = 1'b1;
    shift_bits(fr, C, 1'b0);
    commit();
    for (int k = 0; k < 6; k++) begin
      exp(32'(k % 2));
      check($sformatf("toggle_%0d", k), 32'(OUTPUT_VALS));
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pal_macrocell_array.md
# pal_macrocell_array

Second-generation programmable array logic fabric: a parametrised AND/OR plane with a per-output macrocell that can be combinational or registered and either polarity. Configuration arrives as a serial bitstream into a shadow shift chain, is checked for length, and is applied atomically on commit, so the active logic never sees a partial frame. Sits in the top-level wrapper between the dedicated input pins and the dedicated output pins. Configuration is driven from bidirectional pins set as inputs.

## Interface
- `N`, 8, number of input variables
- `M`, 4, number of outputs/macrocells
- `P`, 14, number of product terms
- Derived: `L` = N (or N+M with feedback); `C` = 2·L·P + M·P + 2·M config bits (288 at defaults without feedback)

- `CLK` in 1 — single clock; all state on rising edge
- `RES_N` in 1 — asynchronous, active-low reset
- `CFG_EN` in 1 — shift one config bit per cycle while high
- `CFG_IN` in 1 — serial config data
- `CFG_COMMIT` in 1 — request copy of shadow chain into active config
- `INPUT_VARS` in N — logic inputs
- `OUTPUT_VALS` out M — macrocell outputs
- `CFG_OUT` out 1 — registered serial tail of shadow chain (daisy-chain/readback)
- `CFG_VALID` out 1 — an accepted commit has occurred since reset
- `CFG_ERR` out 1 — last commit was rejected (wrong length)

## Operation
- Reset (async): shadow chain, active config, bit counter, macrocell flops, `CFG_OUT`, `CFG_VALID`, `CFG_ERR` all 0; `OUTPUT_VALS` = 0.
- Shift: when `CFG_EN`=1, `sr <= {CFG_IN, sr[C-1:1]}`; `CFG_OUT <= sr[0]`. The first bit sent ends at index 0 after C shifts. Bit counter increments, saturating at C+1 (overlength detectable).
- Commit: when `CFG_COMMIT`=1 and `CFG_EN`=0:
  - count == C: active <= sr, `CFG_VALID`<=1, `CFG_ERR`<=0.
  - otherwise: active config unchanged, `CFG_ERR`<=1.
  - Counter cleared in both cases. Shadow chain is not cleared.
- `CFG_COMMIT` and `CFG_EN` both high: the shift is performed. Commit is ignored, with no error flagged.
- Bit map (active config `a`):
  - Row p, literal i: `a[2Lp+2i]` enables true literal, `a[2Lp+2i+1]` enables complement.
  - Product = AND of enabled literals. A row with no enables = 0. True and complement both enabled = 0 naturally.
  - OR plane base B=2LP: `a[B+Pm+p]` connects row p to output m.
  - Macrocell base D=B+MP: `a[D+2m]`=REG, `a[D+2m+1]`=INV.
- Macrocell: `s_m = OR(connected rows) ^ INV`. The flop `q_m <= s_m` every edge in both modes. `OUTPUT_VALS[m] = REG ? q_m : s_m`.
- Before any accepted commit, the active config is all zeros, so all outputs are 0.

## Timing
- Combinational mode: `INPUT_VARS`→`OUTPUT_VALS` has 0 cycles latency (pure logic).
- Registered mode: 1 cycle latency.
- Commit accepted at edge k: new function visible combinationally right after edge k. Registered outputs show the new function at edge k+1.
- `CFG_OUT` lags `sr[0]` by one shifting edge. Bit j of the stream first appears on `CFG_OUT` after C+1 shifts.
- `CFG_VALID`/`CFG_ERR` update on the commit edge.
- Reset asserted mid-shift or mid-operation clears everything, including the active config. Outputs return to 0 asynchronously.

## Configuration
- Macro `PAL_FEEDBACK_EN`.
  - Defined: L=N+M. Literals i≥N are `q_(i-N)`, the macrocell flop output taken regardless of REG, so no combinational loops are possible. C=400 at defaults.
  - Undefined: L=N, no feedback literals, C=288 at defaults.

## Test plan
- Reset: hold `RES_N`=0 with random inputs → all outputs 0, `CFG_VALID`=0, `CFG_ERR`=0.
- AND/OR: shift 288 bits programming row0 = in0·in1, output0 = row0, comb, INV=0; commit → `CFG_VALID`=1. Then `INPUT_VARS`=8'h03 → `OUTPUT_VALS`=4'h1; 8'h01 → 4'h0 in the same cycle.
- Macrocell modes: same frame with REG=1, INV=1 on output0. Apply 8'h03 → output0 stays 1 until the next edge, then becomes 0.
- Length check: shift 287 bits then commit → `CFG_ERR`=1, outputs keep the previous function. Shift 288 bits, commit → `CFG_ERR`=0.
- Readback/collision: shift 288 bits, then 289 more zeros → `CFG_OUT` reproduces the first bits in order. `CFG_COMMIT` together with `CFG_EN` → no commit, no error.
- Feedback (`PAL_FEEDBACK_EN`): program output0 = REG of NOT q0 (toggle) → `OUTPUT_VALS[0]` toggles every cycle starting after commit.
